sequence_generator_moore: RTL and testbench
===========================================

// Module: sequence_generator_moore
// PURPOSE
//  Serial pattern transmitter. Emits a loaded PAT_W-bit pattern MSB-first, one bit per clock, on
//  sequence_out, repeated a requested number of times with optional zero-gap bits between copies.
//  Stimulus end of the serial sequence-detection path; drives the sequence_in of a detector.
//  Output is a registered Moore output: it depends only on state and the shift register.
// PARAMETERS
//  PAT_W     4        pattern length in bits (>=2)
//  PAT_RST   4'b1011  pattern register value after reset
//  CNT_W     4        width of repeat_cnt
//  GAP_BITS  0        forced-0 bits inserted between repetitions (0 = back-to-back)
// PORTS
//  clock         in   1      rising-edge clock
//  reset_n       in   1      asynchronous, active-low reset
//  start         in   1      request a transmission; accepted only when ready=1
//  pattern_in    in   PAT_W  pattern, latched on accept
//  repeat_cnt    in   CNT_W  number of copies, latched on accept; 0 is treated as 1
//  abort         in   1      synchronous cancel of an active transmission
//  ready         out  1      idle and able to accept start
//  busy          out  1      transmission in progress (SHIFT or GAP)
//  sequence_out  out  1      serial bit stream; 0 when not shifting
//  done          out  1      one-cycle pulse after the last bit of the last copy
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE, sequence_out=0, done=0, busy=0, ready=1,
//    pattern reg=PAT_RST, counters=0. Applies immediately, also in the middle of a transmission.
//  - States (Gray-encoded): IDLE, SHIFT, GAP, DONE.
//  - IDLE: ready=1. Accept when start=1 at edge T: latch pattern_in and
//    reps=(repeat_cnt==0)?1:repeat_cnt, bit_idx=PAT_W-1, go to SHIFT.
//  - SHIFT: sequence_out=pattern[bit_idx] for one cycle per bit. The first bit is visible in
//    cycle T+1 (latency 1). bit_idx counts down to 0.
//  - End of a copy (bit_idx==0): decrement reps. If reps remain: go to GAP when GAP_BITS>0,
//    otherwise reload bit_idx=PAT_W-1 and stay in SHIFT with no idle cycle. Otherwise go to DONE.
//  - GAP: sequence_out=0 for exactly GAP_BITS cycles, then SHIFT with bit_idx=PAT_W-1.
//  - DONE: one cycle with done=1 and sequence_out=0, then IDLE.
//    Single copy: done is asserted in cycle T+PAT_W+1 and ready returns in cycle T+PAT_W+2.
//  - start while ready=0 is ignored. It is not queued, and the latched pattern/count are unchanged.
//  - abort=1 in SHIFT or GAP: IDLE at the next edge, sequence_out=0, no done pulse.
//    abort in IDLE or DONE has no effect. abort has priority over start in the same cycle.
//  - busy=1 exactly in SHIFT and GAP. ready=1 exactly in IDLE.
//  - Outputs are registered and glitch-free. Illegal state codes recover to IDLE with all outputs 0.
//  - Counter widths: bit_idx is $clog2(PAT_W) bits, reps is CNT_W bits, the gap counter is
//    $clog2(GAP_BITS+1) bits. No counter may wrap: every counter is reloaded before it underflows.
// STRUCTURE
//  - Shared package seq_pkg: state encodings (IDLE/SHIFT/GAP/DONE, Gray) and default-pattern
//    constant 4'b1011.
//  - One sub-module: sequence_shift_reg. Parallel-load, MSB-first shift register with a
//    load/shift enable, the tap output and a last-bit flag. The FSM, repeat counter and gap
//    counter stay in the top level.
// TESTING  (loop back sequence_out into the 1011 detector, which shares this clock)
//  1. pattern_in=1011, repeat_cnt=1, start at T -> sequence_out 1,0,1,1 in T+1..T+4;
//     done=1 at T+5; ready=1 at T+6; detector fires once.
//  2. 1011, repeat_cnt=3, GAP_BITS=0 -> 12 contiguous bits 101110111011, no idle cycle,
//     detector fires 3 times, single done pulse.
//  3. 1011, repeat_cnt=2, GAP_BITS=2 -> 1011 00 1011, then done.
//     repeat_cnt=0 -> exactly one copy is sent.
//  4. start pulsed with pattern 0000 during busy -> ignored; the stream still carries the
//     original pattern.
//  5. abort during the 3rd bit -> next cycle sequence_out=0 and ready=1, no done pulse.
//     Abort+start in the same cycle -> the abort wins.
//  6. reset_n low during SHIFT (asynchronous, mid-cycle) -> sequence_out=0 and ready=1
//     immediately; after release a new start works normally.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter: Gray-coded FSM
// state constants, the default pattern and a small state-decode helper.
package seq_pkg;

   // Gray sequence IDLE -> SHIFT -> GAP -> DONE: adjacent states differ in one bit
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_GAP   = 2'b11;
   localparam logic [1:0] ST_DONE  = 2'b10;

   // Pattern held in the shift register after reset
   localparam logic [3:0] PAT_DEFAULT = 4'b1011;

   // A transmission is in progress while shifting data or inserting gap bits
   function automatic logic state_is_busy(input logic [1:0] st);
      return (st == ST_SHIFT) || (st == ST_GAP);
   endfunction

endpackage

// File: rtl/sequence_shift_reg.sv
// Parallel-load, MSB-first shift register for the pattern transmitter.
// Shifting rotates the register left, so after PAT_W shifts the original
// pattern is back in place and the next copy needs no reload. The bit index
// counts the remaining bits of the current copy; 'last' flags bit 0.
module sequence_shift_reg #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PAT_RST = 4'b1011
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic             shift,
   input  logic [PAT_W-1:0] data_in,
   output logic             tap,
   output logic             tap_next,
   output logic             last
);

   localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

   logic [PAT_W-1:0] sr_reg;
   logic [PAT_W-1:0] sr_next;
   logic [PAT_W-1:0] rot;
   logic [IDX_W-1:0] idx_reg;
   logic [IDX_W-1:0] idx_next;

   // Rotate-left view of the register: MSB wraps around to bit 0
   assign rot[0] = sr_reg[PAT_W-1];
   generate
      for (genvar gi = 1; gi < PAT_W; gi++) begin : g_rot
         assign rot[gi] = sr_reg[gi-1];
      end
   endgenerate

   // Next register contents and bit index; load wins over shift
   always_comb begin
      sr_next  = sr_reg;
      idx_next = idx_reg;
      if (load) begin
         sr_next  = data_in;
         idx_next = IDX_LAST;
      end else if (shift) begin
         sr_next  = rot;
         // Reload at the end of a copy instead of wrapping below zero
         idx_next = (idx_reg == '0) ? IDX_LAST : (idx_reg - IDX_W'(1));
      end
   end

   // Register update with asynchronous reset to the default pattern
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sr_reg  <= PAT_RST;
         idx_reg <= '0;
      end else begin
         sr_reg  <= sr_next;
         idx_reg <= idx_next;
      end
   end

   assign tap      = sr_reg[PAT_W-1];
   assign tap_next = sr_next[PAT_W-1];
   assign last     = (idx_reg == '0);

endmodule

// File: rtl/sequence_generator_moore.sv
// Serial pattern transmitter. Sends a latched PAT_W-bit pattern MSB-first,
// one bit per clock, a requested number of times with optional zero gap
// bits between copies, then pulses done. All outputs are registered and
// decoded from the next state so they change only on the clock edge.
module sequence_generator_moore
   import seq_pkg::*;
#(
   parameter int               PAT_W    = 4,
   parameter logic [PAT_W-1:0] PAT_RST  = PAT_DEFAULT,
   parameter int               CNT_W    = 4,
   parameter int               GAP_BITS = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic             sequence_out,
   output logic             done
);

   // A zero-bit gap counter is not legal, so keep at least one bit
   localparam int                GAP_CW   = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
   localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'(GAP_BITS);

   logic [1:0]        state_reg;
   logic [1:0]        state_next;
   logic [CNT_W-1:0]  reps_reg;
   logic [CNT_W-1:0]  reps_next;
   logic [GAP_CW-1:0] gap_reg;
   logic [GAP_CW-1:0] gap_next;

   logic              seq_out_reg;
   logic              seq_out_next;
   logic              done_reg;
   logic              done_next;
   logic              busy_reg;
   logic              busy_next;
   logic              ready_reg;
   logic              ready_next;

   logic              sr_load;
   logic              sr_shift;
   logic              sr_tap;
   logic              sr_tap_next;
   logic              sr_last;

   sequence_shift_reg #(
      .PAT_W   (PAT_W),
      .PAT_RST (PAT_RST)
   ) u_shift (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (sr_load),
      .shift    (sr_shift),
      .data_in  (pattern_in),
      .tap      (sr_tap),
      .tap_next (sr_tap_next),
      .last     (sr_last)
   );

   // FSM transitions plus repeat and gap counter bookkeeping
   always_comb begin
      state_next = state_reg;
      reps_next  = reps_reg;
      gap_next   = gap_reg;
      sr_load    = 1'b0;
      sr_shift   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // abort has nothing to cancel here, so start is taken as is
            if (start) begin
               sr_load    = 1'b1;
               reps_next  = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               reps_next  = '0;
               state_next = ST_IDLE;
            end else begin
               sr_shift = 1'b1;
               if (sr_last) begin
                  // reps is at least 1 while shifting, so this never wraps
                  reps_next = reps_reg - CNT_W'(1);
                  if (reps_reg != CNT_W'(1)) begin
                     if (GAP_BITS > 0) begin
                        gap_next   = GAP_LOAD;
                        state_next = ST_GAP;
                     end
                     // without a gap the rotated register already holds
                     // the pattern again, so shifting simply continues
                  end else begin
                     state_next = ST_DONE;
                  end
               end
            end
         end
         ST_GAP: begin
            if (abort) begin
               reps_next  = '0;
               gap_next   = '0;
               state_next = ST_IDLE;
            end else if (gap_reg <= GAP_CW'(1)) begin
               gap_next   = '0;
               state_next = ST_SHIFT;
            end else begin
               gap_next = gap_reg - GAP_CW'(1);
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            reps_next  = '0;
            gap_next   = '0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the next state, registered below
   always_comb begin
      seq_out_next = (state_next == ST_SHIFT) ? sr_tap_next : 1'b0;
      done_next    = (state_next == ST_DONE);
      busy_next    = state_is_busy(state_next);
      ready_next   = (state_next == ST_IDLE);
   end

   // State, counters and output registers with asynchronous reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= ST_IDLE;
         reps_reg    <= '0;
         gap_reg     <= '0;
         seq_out_reg <= 1'b0;
         done_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         ready_reg   <= 1'b1;
      end else begin
         state_reg   <= state_next;
         reps_reg    <= reps_next;
         gap_reg     <= gap_next;
         seq_out_reg <= seq_out_next;
         done_reg    <= done_next;
         busy_reg    <= busy_next;
         ready_reg   <= ready_next;
      end
   end

   assign sequence_out = seq_out_reg;
   assign done         = done_reg;
   assign busy         = busy_reg;
   assign ready        = ready_reg;

   // The current tap is only consumed through tap_next; keep it observable
   logic unused_tap;
   assign unused_tap = sr_tap;

endmodule

// File: tb/tb_sequence_generator_moore.sv
// Bench for the serial pattern transmitter. Two instances share stimulus:
// one sends copies back-to-back, the other inserts two gap bits. A queue
// model builds the expected stream for every accepted request and is
// compared with all outputs of both instances every cycle.
module tb_sequence_generator_moore;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] pattern_in;
   logic [3:0] repeat_cnt;
   logic       abort;

   logic ready0, busy0, seq0, done0;
   logic ready2, busy2, seq2, done2;

   int checks = 0;
   int errors = 0;

   sequence_generator_moore #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(4), .GAP_BITS(0)) dut0 (
      .clock        (clk),
      .reset_n      (rst_n),
      .start        (start),
      .pattern_in   (pattern_in),
      .repeat_cnt   (repeat_cnt),
      .abort        (abort),
      .ready        (ready0),
      .busy         (busy0),
      .sequence_out (seq0),
      .done         (done0)
   );

   sequence_generator_moore #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(4), .GAP_BITS(2)) dut2 (
      .clock        (clk),
      .reset_n      (rst_n),
      .start        (start),
      .pattern_in   (pattern_in),
      .repeat_cnt   (repeat_cnt),
      .abort        (abort),
      .ready        (ready2),
      .busy         (busy2),
      .sequence_out (seq2),
      .done         (done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per instance, the cycle shown now plus the queued
   // future cycles. Entry bits are {busy, done, sequence_out}.
   logic [2:0] mq0 [0:255];
   logic [2:0] mq1 [0:255];
   int         mhead [2];
   int         mtail [2];
   logic [2:0] mcur [2];
   bit         mvalid [2];

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic mpush(input int k, input logic [2:0] e);
      if (k == 0) mq0[mtail[k]] = e;
      else        mq1[mtail[k]] = e;
      mtail[k]++;
   endtask

   task automatic mpop(input int k);
      if (mhead[k] < mtail[k]) begin
         mcur[k]   = (k == 0) ? mq0[mhead[k]] : mq1[mhead[k]];
         mvalid[k] = 1'b1;
         mhead[k]++;
      end else begin
         mcur[k]   = 3'b000;
         mvalid[k] = 1'b0;
      end
   endtask

   task automatic mclear(input int k);
      mhead[k]  = 0;
      mtail[k]  = 0;
      mcur[k]   = 3'b000;
      mvalid[k] = 1'b0;
   endtask

   // One clock edge of the model, given the inputs sampled at that edge
   task automatic model_step(input int k, input bit s, input logic [3:0] p,
                             input logic [3:0] c, input bit a);
      int gap;
      int reps;
      gap = (k == 0) ? 0 : 2;
      if (mvalid[k] && mcur[k][2] && a) begin
         mclear(k);
      end else if (!mvalid[k]) begin
         if (s) begin
            mclear(k);
            reps = (c == 4'd0) ? 1 : int'(c);
            for (int r = 0; r < reps; r++) begin
               for (int b = 3; b >= 0; b--) mpush(k, {1'b1, 1'b0, p[b]});
               if (r < reps - 1)
                  for (int g = 0; g < gap; g++) mpush(k, 3'b100);
            end
            mpush(k, 3'b010);
            mpop(k);
            $display("txn dut%0d: pattern %b repeat_cnt %0d gap %0d", k, p, c, gap);
         end
      end else begin
         mpop(k);
      end
   endtask

   task automatic check_all();
      logic [3:0] obs [2];
      obs[0] = {seq0, done0, busy0, ready0};
      obs[1] = {seq2, done2, busy2, ready2};
      for (int k = 0; k < 2; k++) begin
         check_value($sformatf("dut%0d sequence_out", k), 32'(obs[k][3]), 32'(mcur[k][0]));
         check_value($sformatf("dut%0d done", k),         32'(obs[k][2]), 32'(mcur[k][1]));
         check_value($sformatf("dut%0d busy", k),         32'(obs[k][1]), 32'(mcur[k][2]));
         check_value($sformatf("dut%0d ready", k),        32'(obs[k][0]), 32'(!mvalid[k]));
      end
   endtask

   // Drive one cycle of inputs, step the model at the edge, check at negedge
   task automatic cycle(input bit s, input logic [3:0] p, input logic [3:0] c, input bit a);
      start      = s;
      pattern_in = p;
      repeat_cnt = c;
      abort      = a;
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, s, p, c, a);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'd0, 1'b0);
   endtask

   initial begin
      bit         s;
      bit         a;
      logic [3:0] p;
      logic [3:0] c;

      rst_n      = 1'b0;
      start      = 1'b0;
      pattern_in = 4'd0;
      repeat_cnt = 4'd0;
      abort      = 1'b0;
      for (int k = 0; k < 2; k++) mclear(k);

      // Reset state
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(2);

      // Single copy, then three copies, then two copies (gap visible on dut2)
      cycle(1'b1, 4'b1011, 4'd1, 1'b0);
      idle_cycles(7);
      cycle(1'b1, 4'b1011, 4'd3, 1'b0);
      idle_cycles(20);
      cycle(1'b1, 4'b1011, 4'd2, 1'b0);
      idle_cycles(14);
      // repeat_cnt of zero sends one copy
      cycle(1'b1, 4'b0110, 4'd0, 1'b0);
      idle_cycles(7);

      // start while busy is ignored
      cycle(1'b1, 4'b1011, 4'd2, 1'b0);
      idle_cycles(2);
      cycle(1'b1, 4'b0000, 4'd5, 1'b0);
      idle_cycles(14);

      // abort while the third bit is shown, then abort together with start
      cycle(1'b1, 4'b1011, 4'd1, 1'b0);
      idle_cycles(2);
      cycle(1'b0, 4'd0, 4'd0, 1'b1);
      idle_cycles(2);
      cycle(1'b1, 4'b1101, 4'd2, 1'b0);
      cycle(1'b1, 4'b0000, 4'd1, 1'b1);
      idle_cycles(3);

      // Asynchronous reset in the middle of a transmission
      cycle(1'b1, 4'b1111, 4'd3, 1'b0);
      idle_cycles(2);
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) mclear(k);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 4'b1001, 4'd1, 1'b0);
      idle_cycles(7);

      // Randomized traffic
      for (int i = 0; i < 2500; i++) begin
         s = ($urandom_range(0, 3) == 0);
         p = 4'($urandom_range(0, 15));
         c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         a = ($urandom_range(0, 24) == 0);
         // keep abort+start away from an idle instance
         if (a && (!mvalid[0] || !mvalid[1])) s = 1'b0;
         cycle(s, p, c, a);
      end
      idle_cycles(120);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
